spi_slave_rx: RTL

//  - Oversampled SPI slave (mode 0, MSB first): the stage directly downstream of spi_master inside the bridge.
//  - Resynchronises sclk_i/slave_sel_i/mosi_i into clk_i and deserialises one WIDTH-bit frame.
//  - Presents the frame on a valid/ready interface to the I2C command stage and returns tx_data_i on miso_o.
//  - slave_ready_o drives spi_master.slave_ready_i, providing back-pressure.

---
 rtl/spi_bridge_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_slave_rx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI/I2C bridge: slave FSM encoding and default frame geometry.
// Used by spi_master, spi_slave_rx and the I2C command stage.
package spi_bridge_pkg;

    localparam int SPI_WIDTH_DEFAULT       = 8;
    localparam int SPI_SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pad, with a history flop that
// turns transitions of the synchronised level into single-cycle rise/fall pulses.
module spi_sync_edge
    import spi_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
    input  logic clk_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: the chain has no reset so it keeps tracking the pad while reset_i is high;
    // releasing reset mid-frame therefore never produces a phantom edge.
    // Sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        sync_q <= sync_d;
        hist_q <= hist_d;
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~hist_q;
    assign fall_o = ~sync_o & hist_q;

endmodule

// File: rtl/spi_slave_rx.sv
// Oversampled SPI mode-0 slave: deserialises one MSB-first frame into a valid/ready port.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float miso_o while idle or in reset.
module spi_slave_rx
    import spi_bridge_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             sclk_i,
    input  logic             slave_sel_i,
    input  logic             mosi_i,
    output logic             miso_o,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             slave_ready_o,
    output logic             overrun_o,
    output logic             frame_err_o
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic sclk_rise, sclk_fall, sclk_sync_unused;
    logic sel_rise, sel_fall, sel_sync_unused;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i (clk_i), .d_i (sclk_i),
        .sync_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
        .clk_i (clk_i), .d_i (slave_sel_i),
        .sync_o(sel_sync_unused), .rise_o(sel_rise), .fall_o(sel_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i (clk_i), .d_i (mosi_i),
        .sync_o(mosi_sync), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    spi_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             miso_q, miso_d;
    logic             slave_ready_q, slave_ready_d;
    logic             complete, accept;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        miso_d        = miso_q;
        overrun_d     = 1'b0;
        frame_err_d   = 1'b0;
        slave_ready_d = ~rx_valid_q;
        complete      = 1'b0;
        accept        = rx_valid_q & rx_ready_i;

        case (state_q)
            ST_IDLE: begin
                if (sel_fall) begin
                    tx_shift_d = tx_data_i;
                    miso_d     = tx_data_i[WIDTH-1];
                    count_d    = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_d = (rx_shift_q << 1) | WIDTH'(mosi_sync);
                    count_d    = count_q + CW'(1);
                    complete   = (count_q == LAST_BIT);
                end else if (sclk_fall) begin
                    tx_shift_d = tx_shift_q << 1;
                    miso_d     = tx_shift_q[WIDTH-2];
                end
                // A select rise coinciding with the last bit still delivers the frame.
                if (sel_rise) begin
                    state_d     = ST_IDLE;
                    count_d     = '0;
                    miso_d      = 1'b0;
                    frame_err_d = ~complete;
                end else if (complete) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (sel_rise) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    miso_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Completion on the accepting cycle reloads the port instead of overrunning.
        if (complete && (!rx_valid_q || accept)) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
        end else if (complete) begin
            overrun_d = 1'b1;
        end else if (accept) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            overrun_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            miso_q        <= 1'b0;
            slave_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            overrun_q     <= overrun_d;
            frame_err_q   <= frame_err_d;
            miso_q        <= miso_d;
            slave_ready_q <= slave_ready_d;
        end
    end

    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign overrun_o     = overrun_q;
    assign frame_err_o   = frame_err_q;
    assign slave_ready_o = slave_ready_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso_o = (state_q == ST_IDLE || reset_i) ? 1'bz : miso_q;
`else
    assign miso_o = (state_q == ST_IDLE || reset_i) ? 1'b0 : miso_q;
`endif

endmodule
